// File: rtl/downsampler_2x2.sv
// 2x2 block-average downsampler: 800x600 grayscale stream to 400x300.
// Even rows leave pair sums in a line buffer; odd rows finish the block.
module downsampler_2x2 #(
  parameter int IN_COLS = 800,
  parameter int IN_ROWS = 600,
  parameter int DATA_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              out_full,
  output logic [9:0]        in_colcount,
  output logic [9:0]        in_rowcount,
  output logic [DATA_W-1:0] dataout,
  output logic              validout,
  output logic [8:0]        out_colcount,
  output logic [8:0]        out_rowcount,
  output logic              frame_done,
  output logic              overflow
);

  localparam int AW = (IN_COLS > 2) ? $clog2(IN_COLS / 2) : 1;
  localparam int SW = DATA_W + 2;

  logic [9:0]        col_q, col_d;
  logic [9:0]        row_q, row_d;
  logic [DATA_W-1:0] p0_q;
  logic [DATA_W:0]   rd_q;
  logic [DATA_W:0]   psum;
  logic [SW-1:0]     sum_d;
  logic [AW-1:0]     addr;
  logic              col_last, row_last;
  logic              wr_en, rd_en, fire;

  logic [DATA_W-1:0] do_q, do_d;
  logic [8:0]        oc_q, oc_d;
  logic [8:0]        or_q, or_d;
  logic              vo_q, fd_q, fd_d;
  logic              ovf_q;

  logic [DATA_W:0]   mem [IN_COLS/2];

  assign col_last = (col_q == 10'(IN_COLS - 1));
  assign row_last = (row_q == 10'(IN_ROWS - 1));
  assign addr     = col_q[AW:1];

  assign wr_en = valid & ~row_q[0] & col_q[0];
  assign rd_en = valid & row_q[0] & ~col_q[0];
  assign fire  = valid & row_q[0] & col_q[0];

  assign psum  = {1'b0, p0_q} + {1'b0, data};
  // +2 before the shift gives round-half-up
  assign sum_d = SW'(rd_q) + SW'(p0_q) + SW'(data) + SW'(2);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  always_comb begin
    do_d = do_q;
    oc_d = oc_q;
    or_d = or_q;
    fd_d = 1'b0;
    if (fire) begin
      do_d = DATA_W'(sum_d >> 2);
      oc_d = col_q[9:1];
      or_d = row_q[9:1];
      fd_d = col_last & row_last;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
      p0_q  <= '0;
      rd_q  <= '0;
      do_q  <= '0;
      oc_q  <= '0;
      or_q  <= '0;
      vo_q  <= 1'b0;
      fd_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (valid && !col_q[0]) p0_q <= data;
      if (rd_en) rd_q <= mem[addr];
      do_q  <= do_d;
      oc_q  <= oc_d;
      or_q  <= or_d;
      vo_q  <= fire;
      fd_q  <= fd_d;
      ovf_q <= ovf_q | (vo_q & out_full);
    end
  end

  // Line buffer RAM: contents survive reset and are don't-care
  always_ff @(posedge clock) begin
    if (wr_en) mem[addr] <= psum;
  end

  assign in_colcount  = col_q;
  assign in_rowcount  = row_q;
  assign dataout      = do_q;
  assign validout     = vo_q;
  assign out_colcount = oc_q;
  assign out_rowcount = or_q;
  assign frame_done   = fd_q;
  assign overflow     = ovf_q | (vo_q & out_full);

endmodule

// File: tb/tb_downsampler_2x2.sv
// Directed bench for downsampler_2x2 on a reduced 16x8 frame.
// Scoreboard queue holds expected outputs pushed at the trigger beat.
module tb_downsampler_2x2;

  localparam int C  = 16;
  localparam int R  = 8;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          valid;
  logic [DW-1:0] data;
  logic          out_full;
  logic [9:0]    in_colcount, in_rowcount;
  logic [DW-1:0] dataout;
  logic          validout;
  logic [8:0]    out_colcount, out_rowcount;
  logic          frame_done, overflow;

  downsampler_2x2 #(.IN_COLS(C), .IN_ROWS(R), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .valid(valid), .data(data),
    .out_full(out_full), .in_colcount(in_colcount),
    .in_rowcount(in_rowcount), .dataout(dataout), .validout(validout),
    .out_colcount(out_colcount), .out_rowcount(out_rowcount),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    int d;
    int oc;
    int orow;
    int fd;
  } exp_t;

  exp_t q[$];
  int   outlog[$];
  int   loga[$];
  int   pix [R][C];
  int   mcol, mrow;
  int   checks = 0;
  int   errors = 0;
  int   nout, nfd;
  bit   prev_out, ovf_sticky;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pix_of(input int mode, input int r, input int c);
    int v;
    v = (r * 7 + c * 3) & 255;
    if (mode == 0) v = 8'h80;
    if (mode == 1 && r < 2 && c < 10) begin
      case (r * 16 + c)
        0: v = 10;   1: v = 20;   16: v = 30;  17: v = 41;
        2: v = 1;    3: v = 1;    18: v = 1;   19: v = 0;
        4: v = 1;    5: v = 1;    20: v = 0;   21: v = 0;
        6: v = 1;    7: v = 0;    22: v = 0;   23: v = 0;
        default: v = 255;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    mcol = 0;
    mrow = 0;
    q.delete();
    prev_out = 1'b0;
    ovf_sticky = 1'b0;
  endtask

  task automatic step(input bit v, input int d, input bit full);
    bit   exp_out;
    int   s;
    exp_t e;
    valid = v;
    data = DW'(d);
    out_full = full;
    exp_out = 1'b0;
    if (v) begin
      pix[mrow][mcol] = d;
      if ((mrow % 2) == 1 && (mcol % 2) == 1) begin
        s = pix[mrow-1][mcol-1] + pix[mrow-1][mcol] + pix[mrow][mcol-1] + d;
        e.d = (s + 2) / 4;
        e.oc = mcol / 2;
        e.orow = mrow / 2;
        e.fd = (mcol == C - 1 && mrow == R - 1) ? 1 : 0;
        q.push_back(e);
        exp_out = 1'b1;
      end
      if (mcol == C - 1) begin
        mcol = 0;
        mrow = (mrow == R - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    ovf_sticky = ovf_sticky | (prev_out & full);
    @(posedge clock);
    #1;
    prev_out = exp_out;
    chk("in_colcount", 32'(in_colcount), mcol);
    chk("in_rowcount", 32'(in_rowcount), mrow);
    chk("validout", 32'(validout), 32'(exp_out));
    chk("overflow", 32'(overflow), 32'(ovf_sticky | (exp_out & full)));
    if (validout && q.size() > 0) begin
      e = q.pop_front();
      chk("dataout", 32'(dataout), e.d);
      chk("out_colcount", 32'(out_colcount), e.oc);
      chk("out_rowcount", 32'(out_rowcount), e.orow);
      chk("frame_done", 32'(frame_done), e.fd);
      outlog.push_back(32'(dataout));
      nout++;
      if (frame_done) nfd++;
    end else if (!validout) begin
      chk("frame_done_idle", 32'(frame_done), 0);
    end
  endtask

  task automatic next_beat(input int mode, input bit full);
    step(1'b1, pix_of(mode, mrow, mcol), full);
  endtask

  task automatic run_frame(input int mode, input int gapmax);
    for (int i = 0; i < R * C; i++) begin
      if (gapmax > 0) begin
        int g;
        g = $urandom_range(0, gapmax);
        for (int k = 0; k < g; k++) step(1'b0, 0, 1'b0);
      end
      next_beat(mode, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b0;
    valid = 1'b0;
    data = '0;
    out_full = 1'b0;
    model_reset();
    #2;
    chk("rst_in_col", 32'(in_colcount), 0);
    chk("rst_in_row", 32'(in_rowcount), 0);
    chk("rst_validout", 32'(validout), 0);
    chk("rst_dataout", 32'(dataout), 0);
    chk("rst_overflow", 32'(overflow), 0);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;

    // constant frame followed directly by a directed frame (wrap)
    nout = 0;
    nfd = 0;
    run_frame(0, 0);
    chk("const_outputs", nout, (R / 2) * (C / 2));
    chk("const_frame_done", nfd, 1);
    outlog.delete();
    run_frame(1, 0);
    chk("blk_avg", outlog[0], 25);
    chk("rnd_1110", outlog[1], 1);
    chk("rnd_1100", outlog[2], 1);
    chk("rnd_1000", outlog[3], 0);
    chk("rnd_ffff", outlog[4], 255);

    // ramp without gaps, then the same ramp with idle gaps
    outlog.delete();
    run_frame(2, 0);
    loga = outlog;
    outlog.delete();
    run_frame(2, 5);
    chk("gap_count", outlog.size(), loga.size());
    for (int i = 0; i < loga.size() && i < outlog.size(); i++)
      chk("gap_equal", outlog[i], loga[i]);

    // out_full during the first output of a frame
    for (int i = 0; i < C + 1; i++) next_beat(2, 1'b0);
    next_beat(2, 1'b0);
    out_full = 1'b1;
    #1;
    chk("ovf_rise", 32'(overflow), 1);
    next_beat(2, 1'b1);
    for (int i = 0; i < 4; i++) next_beat(2, 1'b0);
    chk("ovf_sticky", 32'(overflow), 1);

    // reset in the middle of a row
    while (!(mrow == 5 && mcol == 6)) next_beat(2, 1'b0);
    valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_validout", 32'(validout), 0);
    chk("mid_rst_dataout", 32'(dataout), 0);
    chk("mid_rst_out_col", 32'(out_colcount), 0);
    chk("mid_rst_out_row", 32'(out_rowcount), 0);
    chk("mid_rst_frame_done", 32'(frame_done), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_in_col", 32'(in_colcount), 0);
    chk("mid_rst_in_row", 32'(in_rowcount), 0);
    model_reset();
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;

    outlog.delete();
    nfd = 0;
    run_frame(1, 0);
    chk("post_rst_blk", outlog[0], 25);
    chk("post_rst_ffff", outlog[4], 255);
    chk("post_rst_frame_done", nfd, 1);
    chk("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
